color_update_scheduler: RTL

COLOR_UPDATE_SCHEDULER -- requirements
Module: color_update_scheduler

---
 rtl/color_update_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/color_update_scheduler.sv
// Frame-synchronous color register update scheduler: queues and coalesces
// palette writes, then drains them to the register bank once per commit window.
module color_update_scheduler #(
   parameter int C_ADDR_WIDTH = 3,
   parameter int C_DATA_WIDTH = 8,
   parameter int DEPTH        = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [C_ADDR_WIDTH-1:0]  Req_Addr,
   input  logic [C_DATA_WIDTH-1:0]  Req_Data,
   input  logic                     Req_Valid,
   output logic                     Req_Rdy,
   input  logic                     VSync,
   input  logic                     Frame_Sync_En,
   output logic [C_ADDR_WIDTH-1:0]  C_Addr,
   output logic [C_DATA_WIDTH-1:0]  C_Data,
   output logic                     C_Valid,
   input  logic                     C_Rdy,
   output logic [$clog2(DEPTH):0]   Pending_Count,
   output logic                     Overflow_Error,
   output logic                     Commit_Done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {IDLE, WAIT_WIN, DRAIN} state_t;

   logic [C_ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [C_DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]        rd_ptr, wr_ptr, hit_idx, slot;
   logic [CNT_W-1:0]        count, budget, budget_next;
   state_t                  state, state_next;
   logic                    vsync_q, window_start;
   logic                    ovf_q, done_q, done_next;
   logic                    hit, push, append, coalesce, pop;

   assign Req_Rdy        = (count < CNT_W'(DEPTH));
   assign C_Valid        = (state == DRAIN);
   assign C_Addr         = C_Valid ? addr_mem[rd_ptr] : '0;
   assign C_Data         = C_Valid ? data_mem[rd_ptr] : '0;
   assign Pending_Count  = count;
   assign Overflow_Error = ovf_q;
   assign Commit_Done    = done_q;

   assign window_start = VSync && !vsync_q;
   assign push         = Req_Valid && Req_Rdy;
   assign append       = push && !hit;
   assign coalesce     = push && hit;
   assign pop          = C_Valid && C_Rdy;

   // Newest matching entry wins; the head is off-limits while it is being presented.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      slot    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         slot = rd_ptr + PTR_W'(k);
         if ((CNT_W'(k) < count) && !(k == 0 && C_Valid) &&
             (addr_mem[slot] == Req_Addr)) begin
            hit     = 1'b1;
            hit_idx = slot;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (append) begin
         addr_mem[wr_ptr] <= Req_Addr;
         data_mem[wr_ptr] <= Req_Data;
      end else if (coalesce) begin
         data_mem[hit_idx] <= Req_Data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         vsync_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         vsync_q <= VSync;
         ovf_q   <= Req_Valid && !Req_Rdy;
         if (append) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         if (append && !pop)      count <= count + CNT_ONE;
         else if (!append && pop) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         budget <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         budget <= budget_next;
         done_q <= done_next;
      end
   end

   // Budget snapshots the queue at drain start, so later arrivals wait a window.
   always_comb begin
      state_next  = state;
      budget_next = budget;
      done_next   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               if (Frame_Sync_En) begin
                  state_next = WAIT_WIN;
               end else begin
                  state_next  = DRAIN;
                  budget_next = count;
               end
            end
         end
         WAIT_WIN: begin
            if (window_start || !Frame_Sync_En) begin
               state_next  = DRAIN;
               budget_next = count;
            end
         end
         DRAIN: begin
            if (pop) begin
               budget_next = budget - CNT_ONE;
               if (budget == CNT_ONE) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
